itf_dram_responder: RTL
=======================

Name: itf_dram_responder

Overview:
- Off-chip-side responder for the global interface controller's command/data link.
- Accepts one command beat {Num, DRAM base address, direction}.
- IN2CHIP: reads DRAM and streams Num*RATIO port beats (last-flagged) to the on-chip side.
- OUT2OFF: sinks port beats and writes them to DRAM at consecutive word addresses.

Parameters:
PORT_WIDTH, 128, link data width; also DRAM word width.
SRAM_WIDTH, 256, on-chip word width; RATIO = SRAM_WIDTH/PORT_WIDTH (integer, power of 2).
DRAM_ADDR_WIDTH, 32, DRAM word-address width.
ADDR_WIDTH, 16, width of Num field.
FIFO_DEPTH, 8, read-return FIFO entries (power of 2, >=2); also the cap on outstanding reads.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
GICITF_CmdVld  in  1  current link beat is a command
GICITF_Dat  in  PORT_WIDTH  command or write data from on-chip
GICITF_DatVld  in  1  on-chip beat valid
GICITF_DatLast  in  1  on-chip beat is last
ITFGIC_DatRdy  out  1  responder accepts on-chip beat (command or write data)
ITFGIC_Dat  out  PORT_WIDTH  read data to on-chip
ITFGIC_DatVld  out  1  read data valid
ITFGIC_DatLast  out  1  final read beat
GICITF_DatRdy  in  1  on-chip accepts read beat
ITFDRAM_ReqVld  out  1  DRAM request valid
ITFDRAM_ReqWr  out  1  1 = write, 0 = read
ITFDRAM_Addr  out  DRAM_ADDR_WIDTH  DRAM word address
ITFDRAM_WrDat  out  PORT_WIDTH  write data
DRAMITF_ReqRdy  in  1  DRAM accepts request
DRAMITF_RdDat  in  PORT_WIDTH  read return data
DRAMITF_RdDatVld  in  1  read return valid; in-order; no backpressure
ITFMON_Err  out  1  sticky beat-count mismatch
ITFMON_StallCnt  out  32  perf counter (see Optional Feature)

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; all counters, FIFO and Err cleared; every output 0 except ITFGIC_DatRdy, which is 1 because IDLE accepts commands.
- Reset mid-operation: the transfer is dropped. Read returns arriving in the following cycles are discarded.
- Command decode on GICITF_Dat:
  - bit0 = InOut (1 = OUT2OFF).
  - [32:1] = DRAM base address.
  - [48:33] = Num.
  - Remaining bits are ignored.
- Total = Num*RATIO beats; counter width ADDR_WIDTH+log2(RATIO).
- DRAM address = base + beat index, modulo 2^DRAM_ADDR_WIDTH (wraps silently).
- FSM states: IDLE, RD, WR.
  - IDLE: ITFGIC_DatRdy=1. Command fires on GICITF_CmdVld & GICITF_DatVld & ITFGIC_DatRdy. Base, Total and InOut are latched.
    - Next state is WR if InOut=1, else RD.
    - Num=0: stay IDLE; no traffic.
    - Data beats without CmdVld in IDLE are accepted and dropped.
  - RD, request side:
    - ITFDRAM_ReqVld=1, ReqWr=0 while ReqCnt<Total and (outstanding + FIFO occupancy) < FIFO_DEPTH.
    - ReqCnt increments on ReqVld&ReqRdy.
    - This credit rule guarantees returns never overflow the FIFO.
  - RD, return side:
    - Every DRAMITF_RdDatVld pushes into the FIFO.
    - ITFGIC_DatVld = FIFO not empty; ITFGIC_Dat = FIFO head (first-word fall-through, zero added latency).
    - ITFGIC_DatLast = DatVld & (SentCnt==Total-1).
    - Pop on DatVld&GICITF_DatRdy; push and pop in the same cycle are legal.
    - On the last pop the FSM goes to IDLE next cycle.
  - WR:
    - ITFDRAM_ReqVld = GICITF_DatVld & ~GICITF_CmdVld; ReqWr=1; WrDat = GICITF_Dat.
    - ITFGIC_DatRdy = DRAMITF_ReqRdy (combinational pass-through).
    - Beat fires when GICITF_DatVld & ITFGIC_DatRdy; WrCnt increments.
    - Transfer ends on the first of: a beat with DatLast, or WrCnt reaching Total. The FSM goes to IDLE next cycle.
    - If DatLast and WrCnt==Total-1 disagree on the ending beat, Err is set.
- Err is cleared only by rst.
- ITFGIC_DatRdy=0 in RD.
- All outputs except the WR pass-throughs and FIFO head data are registered.

Optional Feature:
- Macro ITF_PERF_EN.
- Defined: ITFMON_StallCnt counts cycles in RD/WR where no link-side handshake occurs (RD: no pop; WR: no beat fire). It saturates at 2^32-1 and is cleared by rst only.
- Undefined: ITFMON_StallCnt is tied to 0 and no counter logic is synthesised.

Test Plan:
- IN2CHIP, Num=2, base=0x100, DRAM latency 3, GICITF_DatRdy=1 -> 4 reads at 0x100..0x103; 4 beats out in order; DatLast on beat 4 only; IDLE after; Err=0.
- IN2CHIP, Num=8, GICITF_DatRdy held 0 for 40 cycles -> outstanding + occupancy never exceeds 8; no data lost; all 16 beats delivered correctly after release.
- OUT2OFF, Num=3, DRAMITF_ReqRdy toggling 1/0 -> 6 writes to base..base+5 carrying exact beat data; ITFGIC_DatRdy mirrors ReqRdy; Err=0.
- OUT2OFF, Num=2, DatLast on beat 3 -> 3 writes, IDLE after beat 3, Err=1.
- Num=0 command, then base=0xFFFFFFFF Num=1 read -> first: no DRAM requests, stays IDLE; second: addresses 0xFFFFFFFF, 0x0.
- rst asserted mid-RD with 5 reads outstanding -> all outputs at reset values next cycle; late returns ignored; a new command then completes normally.

Source files
------------

// File: rtl/itf_dram_responder.sv
// Off-chip responder for the on-chip link: one command beat starts a DRAM read stream or a DRAM write sink; ITF_PERF_EN adds a stall counter.
// Latency: read beats appear on the link the cycle after DRAM returns them (first-word fall-through); write beats pass straight through to DRAM.
// Backpressure: reads are credit-limited to FIFO_DEPTH in flight, link stalls hold data in the FIFO; writes mirror DRAM ready onto the link.

module itf_resp_fifo #(
    parameter int W     = 128,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic                     empty,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   occ
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

    assign occ   = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[AW-1:0]];
endmodule

module itf_dram_responder #(
    parameter int PORT_WIDTH      = 128,
    parameter int SRAM_WIDTH      = 256,
    parameter int DRAM_ADDR_WIDTH = 32,
    parameter int ADDR_WIDTH      = 16,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       GICITF_CmdVld,
    input  logic [PORT_WIDTH-1:0]      GICITF_Dat,
    input  logic                       GICITF_DatVld,
    input  logic                       GICITF_DatLast,
    output logic                       ITFGIC_DatRdy,
    output logic [PORT_WIDTH-1:0]      ITFGIC_Dat,
    output logic                       ITFGIC_DatVld,
    output logic                       ITFGIC_DatLast,
    input  logic                       GICITF_DatRdy,
    output logic                       ITFDRAM_ReqVld,
    output logic                       ITFDRAM_ReqWr,
    output logic [DRAM_ADDR_WIDTH-1:0] ITFDRAM_Addr,
    output logic [PORT_WIDTH-1:0]      ITFDRAM_WrDat,
    input  logic                       DRAMITF_ReqRdy,
    input  logic [PORT_WIDTH-1:0]      DRAMITF_RdDat,
    input  logic                       DRAMITF_RdDatVld,
    output logic                       ITFMON_Err,
    output logic [31:0]                ITFMON_StallCnt
);
    localparam int RATIO  = SRAM_WIDTH / PORT_WIDTH;
    localparam int LOG_R  = $clog2(RATIO);
    localparam int CNT_W  = ADDR_WIDTH + LOG_R;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CRED_W = AW + 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;

    logic [1:0]                 state;
    logic [DRAM_ADDR_WIDTH-1:0] base;
    logic [CNT_W-1:0]           total;
    logic [CNT_W-1:0]           req_cnt;
    logic [CNT_W-1:0]           sent_cnt;
    logic [CNT_W-1:0]           wr_cnt;
    logic [AW:0]                out_cnt;
    logic                       err;

    logic                       fifo_push;
    logic                       fifo_pop;
    logic                       fifo_empty;
    logic [PORT_WIDTH-1:0]      fifo_head;
    logic [AW:0]                fifo_occ;

    // Command beat layout: bit0 direction, [32:1] base, [48:33] Num.
    logic                       cmd_dir;
    logic [31:0]                cmd_base;
    logic [15:0]                cmd_num;
    logic [CNT_W-1:0]           cmd_total;
    logic                       unused_cmd_bits;

    assign cmd_dir         = GICITF_Dat[0];
    assign cmd_base        = GICITF_Dat[32:1];
    assign cmd_num         = GICITF_Dat[48:33];
    assign cmd_total       = CNT_W'(cmd_num) << LOG_R;
    assign unused_cmd_bits = ^GICITF_Dat[PORT_WIDTH-1:49];

    logic cmd_fire;
    logic credit_ok;
    logic rd_req;
    logic rd_req_fire;
    logic ret_dec;
    logic last_pop;
    logic wr_fire;
    logic wr_last_cnt;
    logic wr_end;

    assign cmd_fire    = (state == ST_IDLE) && GICITF_CmdVld && GICITF_DatVld;
    // Reads in flight plus data parked in the FIFO never exceed its depth,
    // so a return can always be absorbed without DRAM backpressure.
    assign credit_ok   = (CRED_W'(out_cnt) + CRED_W'(fifo_occ)) < CRED_W'(FIFO_DEPTH);
    assign rd_req      = (state == ST_RD) && (req_cnt < total) && credit_ok;
    assign rd_req_fire = rd_req && DRAMITF_ReqRdy;
    assign fifo_push   = (state == ST_RD) && DRAMITF_RdDatVld;
    assign ret_dec     = fifo_push && (out_cnt != '0);
    assign fifo_pop    = !fifo_empty && GICITF_DatRdy;
    assign last_pop    = fifo_pop && (sent_cnt == total - CNT_W'(1));
    assign wr_fire     = (state == ST_WR) && GICITF_DatVld && DRAMITF_ReqRdy;
    assign wr_last_cnt = (wr_cnt == total - CNT_W'(1));
    assign wr_end      = wr_fire && (GICITF_DatLast || wr_last_cnt);

    itf_resp_fifo #(
        .W     (PORT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_dat (DRAMITF_RdDat),
        .pop      (fifo_pop),
        .empty    (fifo_empty),
        .head     (fifo_head),
        .occ      (fifo_occ)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            base     <= '0;
            total    <= '0;
            req_cnt  <= '0;
            sent_cnt <= '0;
            wr_cnt   <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_fire && (cmd_total != '0)) begin
                        base     <= DRAM_ADDR_WIDTH'(cmd_base);
                        total    <= cmd_total;
                        req_cnt  <= '0;
                        sent_cnt <= '0;
                        wr_cnt   <= '0;
                        state    <= cmd_dir ? ST_WR : ST_RD;
                    end
                end
                ST_RD: begin
                    if (rd_req_fire) req_cnt  <= req_cnt + CNT_W'(1);
                    if (fifo_pop)    sent_cnt <= sent_cnt + CNT_W'(1);
                    if (last_pop)    state    <= ST_IDLE;
                end
                ST_WR: begin
                    if (wr_fire) wr_cnt <= wr_cnt + CNT_W'(1);
                    if (wr_end)  state  <= ST_IDLE;
                    // The ending beat must carry both the last flag and the final count.
                    if (wr_fire && (GICITF_DatLast != wr_last_cnt)) err <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_cnt <= '0;
        end else if (rd_req_fire && !ret_dec) begin
            out_cnt <= out_cnt + (AW+1)'(1);
        end else if (!rd_req_fire && ret_dec) begin
            out_cnt <= out_cnt - (AW+1)'(1);
        end
    end

    always_comb begin
        ITFGIC_DatRdy = 1'b0;
        case (state)
            ST_IDLE: ITFGIC_DatRdy = 1'b1;
            ST_WR:   ITFGIC_DatRdy = DRAMITF_ReqRdy;
            default: ITFGIC_DatRdy = 1'b0;
        endcase
    end

    assign ITFGIC_DatVld  = !fifo_empty;
    assign ITFGIC_Dat     = fifo_empty ? '0 : fifo_head;
    assign ITFGIC_DatLast = !fifo_empty && (sent_cnt == total - CNT_W'(1));

    assign ITFDRAM_ReqVld = rd_req ||
                            ((state == ST_WR) && GICITF_DatVld && !GICITF_CmdVld);
    assign ITFDRAM_ReqWr  = (state == ST_WR);
    assign ITFDRAM_Addr   = base + DRAM_ADDR_WIDTH'((state == ST_WR) ? wr_cnt : req_cnt);
    assign ITFDRAM_WrDat  = (state == ST_WR) ? GICITF_Dat : '0;
    assign ITFMON_Err     = err;

`ifdef ITF_PERF_EN
    logic [31:0] stall_cnt;
    logic        stall;

    assign stall = ((state == ST_RD) && !fifo_pop) || ((state == ST_WR) && !wr_fire);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign ITFMON_StallCnt = stall_cnt;
`else
    assign ITFMON_StallCnt = '0;
`endif
endmodule
